// File: rtl/dmem_responder_pkg.sv
// Shared core package: RV32I load/store width codes, control typedefs, responder FSM
// states and byte-lane helpers. Used with the DMEM_MISALIGN_TRAP_EN build option.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Low address bits after forcing halfword/word accesses down to their natural boundary.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_BU:   return {24'h0, s[7:0]};
      F3_HU:   return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for dmem_responder: byte-enabled synchronous write and synchronous
// read, both performed only on an enabled edge. Contents are never reset.
module dmem_array #(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Read returns the pre-write word; stores never report data, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, held response.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of aligning down.
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import dmem_responder_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dmem_req_t     req_q, req_d;
  dmem_req_t     cur;
  logic          commit;
  logic          err;
  logic [1:0]    off;
  logic [31:0]   arr_rdata;

  // With zero wait states the array is accessed on the acceptance edge itself, so the
  // live request fields are used while IDLE and the captured ones afterwards.
  always_comb begin
    cur     = (state_q == IDLE) ? dmem_req_t'{we: req_we, funct3: req_funct3,
                                              addr: req_addr, wdata: req_wdata}
                                : req_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = cur;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    off = align_off(cur.funct3, cur.addr[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
    err = !funct3_ok(cur.we, cur.funct3) || misaligned(cur.funct3, cur.addr[1:0]);
`else
    err = !funct3_ok(cur.we, cur.funct3);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (commit && !rst),
    .we    (cur.we && !err),
    .be    (lane_be(cur.funct3, off)),
    .idx   (cur.addr[AW+1:2]),
    .wdata (lane_wdata(cur.funct3, cur.wdata)),
    .rdata (arr_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err;
  assign rsp_rdata = ((state_q == RESP) && !err && !req_q.we)
                     ? load_extend(req_q.funct3, arr_rdata, off) : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states, one with none,
// checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [1:0]       rsp_valid;
  logic             rsp_ready;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_m [2][DEPTH*4];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array; wrap by byte address modulo DEPTH*4.
  task automatic model(input int sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eerr);
    int size, base;
    bit ok, mis;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok   = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    base = int'(a % (DEPTH*4));
    mis  = (size == 2 && base % 2 != 0) || (size == 4 && base % 4 != 0);
    erd  = 32'h0;
    eerr = 1'b0;
    if (!ok || (mis && TRAP)) begin
      eerr = 1'b1;
    end else begin
      base = base - base % size;
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[sel][base+i] = 8'(wd >> (8*i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_m[sel][base+i]) << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
        erd = v;
      end
    end
  endtask

  task automatic run(input int sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eerr;
    int          lat;
    bit          got;
    model(sel, we, f3, a, wd, erd, eerr);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    req_valid[sel] = 1'b1;
    check("req_ready_idle", 32'(req_ready[sel]), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    got = 0;
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[sel]) got = 1;
    end
    check("latency", 32'(lat), (sel == 0) ? 32'd3 : 32'd1);
    rd = rsp_rdata[sel];
    er = rsp_err[sel];
    check("rsp_rdata", rd, erd);
    check("rsp_err", 32'(er), 32'(eerr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[sel]), 32'd1);
      check("hold_rdata", rsp_rdata[sel], erd);
      check("hold_err", 32'(rsp_err[sel]), 32'(eerr));
      check("hold_req_ready", 32'(req_ready[sel]), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("idle_valid", 32'(rsp_valid[sel]), 32'd0);
    check("idle_rdata", rsp_rdata[sel], 32'h0);
  endtask

  initial begin
    logic [31:0] rd, prior;
    logic        er;
    logic        we_r;
    logic [2:0]  f3_r;
    logic [31:0] a_r;

    rst = 1'b1; req_valid = '0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #3;
    for (int s = 0; s < 2; s++) begin
      check("rst_req_ready", 32'(req_ready[s]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[s], 32'h0);
      check("rst_rsp_err", 32'(rsp_err[s]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Known contents for bytes 0x00-0x7F of both arrays.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 32; w++) run(s, 1'b1, 3'b010, 32'(w*4), $urandom, 0, rd, er);

    run(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("sw_rdata_zero", rd, 32'h0);
    run(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEADBEEF);

    run(0, 1'b1, 3'b000, 32'h13, 32'h00000080, 0, rd, er);
    run(0, 1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er);
    check("lb_sext", rd, 32'hFFFFFF80);
    run(0, 1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er);
    check("lbu_zext", rd, 32'h00000080);
    run(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    check("lw_after_sb", rd, 32'h80ADBEEF);

    run(0, 1'b1, 3'b001, 32'h12, 32'h00001234, 0, rd, er);
    run(0, 1'b0, 3'b001, 32'h12, 32'h0, 5, rd, er);
    check("lh_1234", rd, 32'h00001234);

    run(0, 1'b0, 3'b010, 32'h11, 32'h0, 0, rd, er);
    check("lw_mis_err", 32'(er), TRAP ? 32'd1 : 32'd0);
    check("lw_mis_rdata", rd, TRAP ? 32'h0 : 32'h1234BEEF);

    // Reset while a store sits in WAIT: the store must be dropped.
    model(0, 1'b0, 3'b010, 32'h20, 32'h0, prior, er);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h55;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata[0], 32'h0);
    check("midrst_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    check("lw_prior_contents", rd, prior);

    run(0, 1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er);
    check("f3_011_err", 32'(er), 32'd1);
    check("f3_011_rdata", rd, 32'h0);
    run(0, 1'b1, 3'b111, 32'h10, 32'hFFFFFFFF, 0, rd, er);
    check("sf3_111_err", 32'(er), 32'd1);

    run(1, 1'b1, 3'b010, 32'h40, 32'h11223344, 0, rd, er);
    run(1, 1'b0, 3'b101, 32'h42, 32'h0, 0, rd, er);
    check("w0_lhu", rd, 32'h00001122);
    run(1, 1'b0, 3'b000, 32'h43, 32'h0, 2, rd, er);
    check("w0_lb", rd, 32'h00000011);

    // Random traffic with address aliases above the array size.
    for (int n = 0; n < 60; n++) begin
      we_r = 1'($urandom);
      f3_r = 3'($urandom);
      a_r  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
      run(n % 3 == 2 ? 1 : 0, we_r, f3_r, a_r, $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
